// File: rtl/cube_lcd_frame_scanner.sv
// Frame scanner: snapshots cube state, rasters x/y into the pixel
// renderer and streams registered RGB565 pixels over valid/ready.
//
// Ports:
//   clock, reset          system clock, async active-high reset
//   frame_req             pulse: draw one frame
//   state_update          pulse: new cube state present (also draws)
//   cube_state_in         live cube state, sampled at frame start
//   cube_state            frozen snapshot toward the renderer
//   x, y                  scan coordinates toward the renderer
//   render_pixel          renderer result for current x/y
//   pixel_data/valid/
//   ready/first/last      pixel stream toward the LCD write engine
//   busy                  frame in progress
//   frame_done            pulse after the last pixel transfers
module cube_lcd_frame_scanner #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int X_W    = 9,
  parameter int Y_W    = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           frame_req,
  input  logic           state_update,
  input  logic [143:0]   cube_state_in,
  output logic [143:0]   cube_state,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  input  logic [15:0]    render_pixel,
  output logic [15:0]    pixel_data,
  output logic           pixel_valid,
  input  logic           pixel_ready,
  output logic           pixel_first,
  output logic           pixel_last,
  output logic           busy,
  output logic           frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    SNAP,
    STREAM,
    DRAIN
  } state_t;

  state_t         state_q, state_d;
  logic           pending_q, pending_d;
  logic [143:0]   cube_q, cube_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           rem_q, rem_d;
  logic [15:0]    data_q, data_d;
  logic           valid_q, valid_d;
  logic           first_q, first_d;
  logic           last_q, last_d;
  logic           done_q, done_d;

  logic req;
  logic x_end;
  logic y_end;
  logic load;

  assign req   = frame_req | state_update;
  assign x_end = (x_q == X_W'(WIDTH - 1));
  assign y_end = (y_q == Y_W'(HEIGHT - 1));
  // Refill the output register when it is empty or being drained.
  assign load  = rem_q & (~valid_q | pixel_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      cube_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      rem_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cube_q    <= cube_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | req;
    cube_d    = cube_q;
    x_d       = x_q;
    y_d       = y_q;
    rem_d     = rem_q;
    data_d    = data_q;
    valid_d   = valid_q;
    first_d   = first_q;
    last_d    = last_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A fresh request starts the frame directly; pending only
        // survives when a queued request and a new one coincide.
        if (pending_q | req) begin
          state_d   = SNAP;
          pending_d = pending_q & req;
        end
      end
      SNAP: begin
        cube_d  = cube_state_in;
        x_d     = '0;
        y_d     = '0;
        rem_d   = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (load) begin
          data_d  = render_pixel;
          valid_d = 1'b1;
          first_d = (x_q == '0) & (y_q == '0);
          last_d  = x_end & y_end;
          if (x_end & y_end) begin
            rem_d   = 1'b0;
            state_d = DRAIN;
          end else if (x_end) begin
            x_d = '0;
            y_d = y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
          end
        end else if (pixel_ready) begin
          valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (valid_q & pixel_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cube_state  = cube_q;
  assign x           = x_q;
  assign y           = y_q;
  assign pixel_data  = data_q;
  assign pixel_valid = valid_q;
  assign pixel_first = first_q;
  assign pixel_last  = last_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = done_q;

endmodule

// File: tb/tb_cube_lcd_frame_scanner.sv
// Scoreboard bench for cube_lcd_frame_scanner: a 4x2 instance for
// stream/stall/snapshot/reset cases and a default 320x240 instance.
module tb_cube_lcd_frame_scanner;

  typedef struct {
    logic [15:0] d;
    logic        f;
    logic        l;
  } exp_t;

  localparam logic [143:0] CA = {9{16'hA5C3}};
  localparam logic [143:0] CB = {9{16'h1234}};
  localparam logic [143:0] CC = {9{16'h0F0F}};
  localparam logic [143:0] CD = {9{16'h5AA5}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int req_cyc = 0;
  int xfer = 0;
  int done_cnt = 0;
  bit rnd = 1'b0;
  exp_t exq[$];

  logic         rst;
  logic         s_req, s_upd, s_ready;
  logic [143:0] s_cs, s_cube;
  logic [8:0]   s_x;
  logic [7:0]   s_y;
  logic [15:0]  s_rend, s_data;
  logic         s_valid, s_first, s_last, s_busy, s_done;

  logic         d_req, d_upd, d_ready;
  logic [143:0] d_cs, d_cube;
  logic [8:0]   d_x;
  logic [7:0]   d_y;
  logic [15:0]  d_rend, d_data;
  logic         d_valid, d_first, d_last, d_busy, d_done;

  function automatic logic [15:0] rend(input logic [143:0] cs,
                                       input logic [8:0] xx,
                                       input logic [7:0] yy);
    return cs[15:0] ^ {yy[6:0], xx};
  endfunction

  assign s_rend = rend(s_cube, s_x, s_y);
  assign d_rend = rend(d_cube, d_x, d_y);

  cube_lcd_frame_scanner #(.WIDTH(4), .HEIGHT(2), .X_W(9), .Y_W(8)) u_small (
    .clock(clk), .reset(rst), .frame_req(s_req), .state_update(s_upd),
    .cube_state_in(s_cs), .cube_state(s_cube), .x(s_x), .y(s_y),
    .render_pixel(s_rend), .pixel_data(s_data), .pixel_valid(s_valid),
    .pixel_ready(s_ready), .pixel_first(s_first), .pixel_last(s_last),
    .busy(s_busy), .frame_done(s_done)
  );

  cube_lcd_frame_scanner u_full (
    .clock(clk), .reset(rst), .frame_req(d_req), .state_update(d_upd),
    .cube_state_in(d_cs), .cube_state(d_cube), .x(d_x), .y(d_y),
    .render_pixel(d_rend), .pixel_data(d_data), .pixel_valid(d_valid),
    .pixel_ready(d_ready), .pixel_first(d_first), .pixel_last(d_last),
    .busy(d_busy), .frame_done(d_done)
  );

  task automatic check(input string n, input logic [63:0] a,
                       input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  task automatic push_frame(input logic [143:0] cs);
    for (int yi = 0; yi < 2; yi++)
      for (int xi = 0; xi < 4; xi++) begin
        exp_t e;
        e.d = rend(cs, 9'(xi), 8'(yi));
        e.f = (xi == 0 && yi == 0);
        e.l = (xi == 3 && yi == 1);
        exq.push_back(e);
      end
  endtask

  task automatic pulse(input bit upd);
    @(posedge clk); #1;
    if (upd) s_upd = 1'b1;
    else s_req = 1'b1;
    req_cyc = cyc;
    @(posedge clk); #1;
    s_upd = 1'b0;
    s_req = 1'b0;
  endtask

  task automatic wait_done(input string n, input int budget, input int lat);
    int t = 0;
    while (!s_done && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({n, "_done_seen"}, 64'(s_done), 64'd1);
    if (s_done) check({n, "_done_lat"}, 64'(cyc - req_cyc), 64'(lat));
  endtask

  task automatic wait_xfer(input string n, input int tgt);
    int t = 0;
    while (xfer < tgt && t < 200) begin
      @(posedge clk);
      t++;
    end
    check({n, "_xfer_reach"}, 64'(xfer >= tgt), 64'd1);
  endtask

  task automatic wait_quiet(input string n);
    int q = 0;
    int t = 0;
    while (q < 6 && t < 400) begin
      @(posedge clk);
      t++;
      if (!s_busy && exq.size() == 0) q++;
      else q = 0;
    end
    check({n, "_quiet"}, 64'(q >= 6), 64'd1);
  endtask

  initial begin
    s_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      s_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard monitor for the small instance.
  bit          done_exp = 1'b0;
  bit          pv_stall = 1'b0;
  logic [15:0] pv_d;
  logic        pv_f, pv_l;

  always @(negedge clk) begin
    if (rst) begin
      pv_stall = 1'b0;
      done_exp = 1'b0;
    end else begin
      if (done_exp) begin
        check("done_after_last", 64'(s_done), 64'd1);
        done_exp = 1'b0;
      end else if (s_done) begin
        check("done_spurious", 64'(s_done), 64'd0);
      end
      if (s_done) done_cnt++;
      if (pv_stall)
        check("stall_hold", {45'd0, s_valid, s_first, s_last, s_data},
              {45'd0, 1'b1, pv_f, pv_l, pv_d});
      if (s_valid && s_ready) begin
        xfer++;
        if (exq.size() == 0) begin
          check("extra_xfer", 64'(xfer), 64'd0);
        end else begin
          exp_t e;
          e = exq.pop_front();
          check("px_data", 64'(s_data), 64'(e.d));
          check("px_flags", {62'd0, s_first, s_last}, {62'd0, e.f, e.l});
        end
        if (s_last) done_exp = 1'b1;
      end
      pv_stall = s_valid & ~s_ready;
      pv_d = s_data;
      pv_f = s_first;
      pv_l = s_last;
    end
  end

  // Counter for the full-size instance.
  int          d_xfer = 0;
  logic [8:0]  d_lx;
  logic [7:0]  d_ly;
  logic [15:0] d_ld, d_fd;

  always @(negedge clk) begin
    if (d_valid && d_ready) begin
      d_xfer++;
      if (d_first) d_fd = d_data;
      if (d_last) begin
        d_lx = d_x;
        d_ly = d_y;
        d_ld = d_data;
      end
    end
  end

  initial begin
    int bx, bd, t;
    rst = 1'b1;
    s_req = 1'b0;
    s_upd = 1'b0;
    s_cs = CA;
    d_req = 1'b0;
    d_upd = 1'b0;
    d_ready = 1'b1;
    d_cs = CD;
    #12;
    check("rst_valid", 64'(s_valid), 64'd0);
    check("rst_busy", 64'(s_busy), 64'd0);
    check("rst_xy", {47'd0, s_x, s_y}, 64'd0);
    check("rst_data", {45'd0, s_data, s_first, s_last, s_done}, 64'd0);
    check("rst_cube", 64'(s_cube == '0), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic frame with ready high.
    bx = xfer;
    push_frame(CA);
    pulse(1'b0);
    wait_done("basic", 50, 11);
    check("basic_xfers", 64'(xfer - bx), 64'd8);
    wait_quiet("basic");

    // Random ready stalls.
    rnd = 1'b1;
    bx = xfer;
    push_frame(CA);
    pulse(1'b0);
    t = 0;
    while (!s_done && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("stall_done_seen", 64'(s_done), 64'd1);
    rnd = 1'b0;
    wait_quiet("stall");
    check("stall_xfers", 64'(xfer - bx), 64'd8);

    // Snapshot: update to B mid-frame, then change input to C.
    bx = xfer;
    bd = done_cnt;
    s_cs = CA;
    push_frame(CA);
    pulse(1'b1);
    wait_xfer("snap3", bx + 3);
    s_cs = CB;
    push_frame(CB);
    pulse(1'b1);
    wait_xfer("snap9", bx + 9);
    s_cs = CC;
    wait_quiet("snap");
    check("snap_frames", 64'(done_cnt - bd), 64'd2);
    check("snap_xfers", 64'(xfer - bx), 64'd16);

    // Three requests during one frame.
    bx = xfer;
    bd = done_cnt;
    s_cs = CA;
    push_frame(CA);
    push_frame(CA);
    pulse(1'b0);
    repeat (2) pulse(1'b0);
    pulse(1'b0);
    wait_quiet("multi");
    check("multi_frames", 64'(done_cnt - bd), 64'd2);
    check("multi_xfers", 64'(xfer - bx), 64'd16);

    // Reset mid-frame.
    bx = xfer;
    bd = done_cnt;
    push_frame(CA);
    pulse(1'b0);
    wait_xfer("rst5", bx + 5);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 64'(s_valid), 64'd0);
    check("midrst_busy", 64'(s_busy), 64'd0);
    check("midrst_xy", {47'd0, s_x, s_y}, 64'd0);
    exq.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    check("midrst_no_done", 64'(done_cnt - bd), 64'd0);
    check("midrst_idle", 64'(s_busy), 64'd0);
    bx = xfer;
    push_frame(CA);
    pulse(1'b0);
    wait_done("restart", 50, 11);
    check("restart_xfers", 64'(xfer - bx), 64'd8);
    wait_quiet("restart");

    // Full-size frame.
    @(posedge clk); #1;
    d_req = 1'b1;
    req_cyc = cyc;
    @(posedge clk); #1;
    d_req = 1'b0;
    t = 0;
    while (!d_done && t < 77000) begin
      @(negedge clk);
      t++;
    end
    check("full_done_seen", 64'(d_done), 64'd1);
    check("full_done_lat", 64'(cyc - req_cyc), 64'd76803);
    check("full_xfers", 64'(d_xfer), 64'd76800);
    check("full_last_xy", {47'd0, d_lx, d_ly}, {47'd0, 9'd319, 8'd239});
    check("full_last_data", 64'(d_ld), 64'(rend(CD, 9'd319, 8'd239)));
    check("full_first_data", 64'(d_fd), 64'(rend(CD, 9'd0, 8'd0)));

    check("queue_empty", 64'(exq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
